// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I memory stage: load/store unit with req/ack data-memory port (optional LSU_MISALIGN_TRAP_EN)
module mem_stage_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [31:0]     ex_instr,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_rd_wr,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            flush,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_rd_wr,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_misalign
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_rd_wr_q, wb_rd_wr_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    // Per-transaction context captured at accept, consumed at mem_ack
    logic [4:0]        rd_q, rd_d;
    logic              is_load_q, is_load_d;
    logic              unsigned_q, unsigned_d;
    size_t             size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              killed_q, killed_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic              is_load;
    logic              is_store;
    logic              accept;
    size_t             size;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [XLEN-1:0]   wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_value;
    logic              unused_instr_bits;

    assign opcode   = ex_instr[6:0];
    assign rd       = ex_instr[11:7];
    assign funct3   = ex_instr[14:12];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign ex_ready = (state_q == S_IDLE);
    assign accept   = ex_valid & ex_ready & ~flush;
    assign unused_instr_bits = ^ex_instr[31:15];

`ifdef LSU_MISALIGN_TRAP_EN
    logic wb_misalign_q, wb_misalign_d;
    logic misaligned;
    assign misaligned  = ((size == SZ_H) && ex_result[0]) ||
                         ((size == SZ_W) && (ex_result[1:0] != 2'b00));
    assign wb_misalign = wb_misalign_q;
`else
    assign wb_misalign = 1'b0;
`endif

    // Access size and byte lane; undefined funct3 falls back to a word access
    always_comb begin
        size = SZ_W;
        if (is_load) begin
            case (funct3)
                3'b000, 3'b100: size = SZ_B;
                3'b001, 3'b101: size = SZ_H;
                default:        size = SZ_W;
            endcase
        end else begin
            case (funct3)
                3'b000:  size = SZ_B;
                3'b001:  size = SZ_H;
                default: size = SZ_W;
            endcase
        end
        case (size)
            SZ_B:    lane = ex_result[1:0];
            SZ_H:    lane = {ex_result[1], 1'b0};
            default: lane = 2'b00;
        endcase
    end

    // Store byte enables and lane-replicated write data
    always_comb begin
        case (size)
            SZ_B: begin
                be    = 4'b0001 << lane;
                wdata = {4{ex_store_data[7:0]}};
            end
            SZ_H: begin
                be    = 4'b0011 << lane;
                wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = ex_store_data;
            end
        endcase
    end

    // Extract and extend the load value from the returned word
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_B:    ld_value = {{24{ld_byte[7] & ~unsigned_q}}, ld_byte};
            SZ_H:    ld_value = {{16{ld_half[15] & ~unsigned_q}}, ld_half};
            default: ld_value = mem_rdata;
        endcase
    end

    // Next-state logic: IDLE accepts, WAIT holds the request until mem_ack
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_rd_wr_d  = wb_rd_wr_q;
        wb_data_d   = wb_data_q;
        rd_d        = rd_q;
        is_load_d   = is_load_q;
        unsigned_d  = unsigned_q;
        size_d      = size_q;
        lane_d      = lane_q;
        killed_d    = killed_q;
`ifdef LSU_MISALIGN_TRAP_EN
        wb_misalign_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!(is_load || is_store)) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        wb_rd_wr_d = ex_rd_wr & (rd != 5'd0);
                        wb_data_d  = ex_result;
`ifdef LSU_MISALIGN_TRAP_EN
                    end else if (misaligned) begin
                        wb_valid_d    = 1'b1;
                        wb_misalign_d = 1'b1;
                        wb_rd_d       = rd;
                        wb_rd_wr_d    = 1'b0;
                        wb_data_d     = ex_result;
`endif
                    end else begin
                        state_d     = S_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {ex_result[XLEN-1:2], 2'b00};
                        mem_be_d    = be;
                        mem_wdata_d = is_store ? wdata : '0;
                        rd_d        = rd;
                        is_load_d   = is_load;
                        unsigned_d  = funct3[2];
                        size_d      = size;
                        lane_d      = lane;
                        killed_d    = 1'b0;
                    end
                end
            end
            default: begin
                if (flush) begin
                    killed_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_be_d   = 4'b0000;
                    wb_valid_d = ~(killed_q | flush);
                    wb_rd_d    = rd_q;
                    wb_rd_wr_d = is_load_q & (rd_q != 5'd0);
                    if (is_load_q) begin
                        wb_data_d = ld_value;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset abandons any open transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_rd_wr_q  <= 1'b0;
            wb_data_q   <= '0;
            rd_q        <= 5'd0;
            is_load_q   <= 1'b0;
            unsigned_q  <= 1'b0;
            size_q      <= SZ_W;
            lane_q      <= 2'b00;
            killed_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            wb_misalign_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_rd_wr_q  <= wb_rd_wr_d;
            wb_data_q   <= wb_data_d;
            rd_q        <= rd_d;
            is_load_q   <= is_load_d;
            unsigned_q  <= unsigned_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            killed_q    <= killed_d;
`ifdef LSU_MISALIGN_TRAP_EN
            wb_misalign_q <= wb_misalign_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_rd_wr  = wb_rd_wr_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [31:0] ex_result;
    logic        ex_rd_wr;
    logic [31:0] ex_store_data;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_rd_wr;
    logic [31:0] wb_data;
    logic        wb_misalign;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] o_addr, o_wdata, o_wb_data;
    logic [3:0]  o_be;
    logic        o_we, o_stable, o_wb_valid, o_wb_rd_wr, o_req_after, o_ready_after, o_ready_wait, o_wb_valid2;
    logic [4:0]  o_wb_rd;
    int          o_req_cycles;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_result(ex_result),
        .ex_rd_wr(ex_rd_wr), .ex_store_data(ex_store_data), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_wr(wb_rd_wr), .wb_data(wb_data),
        .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, op};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive one load/store through accept, nwait request cycles (ack in the last), and writeback
    task automatic mem_txn(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int nwait, input int flush_at);
        ex_valid = 1'b1; ex_instr = instr; ex_result = addr; ex_store_data = sdata; ex_rd_wr = 1'b1;
        step;
        ex_valid = 1'b0;
        o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata;
        o_ready_wait = ex_ready; o_req_cycles = 0; o_stable = 1'b1;
        for (int i = 1; i <= nwait; i++) begin
            if (mem_req) o_req_cycles++;
            if (mem_addr !== o_addr || mem_be !== o_be || mem_we !== o_we ||
                mem_wdata !== o_wdata || wb_valid !== 1'b0) o_stable = 1'b0;
            flush = (i == flush_at);
            if (i == nwait) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
            end
            step;
        end
        mem_ack = 1'b0; flush = 1'b0; mem_rdata = 32'hA5A5_A5A5;
        o_wb_valid = wb_valid; o_wb_data = wb_data; o_wb_rd = wb_rd; o_wb_rd_wr = wb_rd_wr;
        o_req_after = mem_req; o_ready_after = ex_ready;
        step;
        o_wb_valid2 = wb_valid;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ex_valid = 1'b0; ex_instr = '0; ex_result = '0; ex_rd_wr = 1'b0;
        ex_store_data = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'hA5A5_A5A5;
        #12;
        n_checks++; if ({mem_req, mem_we, wb_valid, wb_rd_wr, wb_misalign} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, wb_valid, wb_rd_wr, wb_misalign}); end
        n_checks++; if ({mem_addr, mem_wdata, wb_data, mem_be, wb_rd} !== 105'd0) begin n_fail++; $display("FAIL reset_data: addr %h wdata %h wbdata %h be %b rd %0d expected all 0", mem_addr, mem_wdata, wb_data, mem_be, wb_rd); end
        n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ex_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_passthrough;
        ex_valid = 1'b1; ex_instr = mk(OP_ALU, 3'b000, 5'd5); ex_result = 32'h1234; ex_rd_wr = 1'b1;
        step;
        ex_valid = 1'b0;
        n_checks++; if ({wb_valid, wb_rd_wr, wb_rd} !== {1'b1, 1'b1, 5'd5}) begin n_fail++; $display("FAIL add_wb: valid %b rd_wr %b rd %0d expected 1 1 5", wb_valid, wb_rd_wr, wb_rd); end
        n_checks++; if (wb_data !== 32'h1234) begin n_fail++; $display("FAIL add_data: got %h expected 00001234", wb_data); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL add_no_req: got %b expected 0", mem_req); end
        step;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_pulse: got %b expected 0", wb_valid); end
    endtask

    task automatic test_back_to_back;
        ex_valid = 1'b1; ex_instr = mk(OP_ALU, 3'b000, 5'd8); ex_result = 32'hAAAA_0001; ex_rd_wr = 1'b1;
        step;
        n_checks++; if ({wb_valid, wb_data} !== {1'b1, 32'hAAAA_0001}) begin n_fail++; $display("FAIL b2b_first: valid %b data %h expected 1 aaaa0001", wb_valid, wb_data); end
        ex_instr = mk(OP_ALU, 3'b000, 5'd0); ex_result = 32'hBBBB_0002;
        step;
        ex_valid = 1'b0;
        n_checks++; if ({wb_valid, wb_data, wb_rd_wr} !== {1'b1, 32'hBBBB_0002, 1'b0}) begin n_fail++; $display("FAIL b2b_second_x0: valid %b data %h rd_wr %b expected 1 bbbb0002 0", wb_valid, wb_data, wb_rd_wr); end
        step;
    endtask

    task automatic test_load;
        mem_txn(mk(OP_LOAD, 3'b000, 5'd7), 32'h1003, 32'h0, 32'h80FF_0000, 3, 0);
        n_checks++; if ({o_addr, o_be, o_we} !== {32'h1000, 4'b1000, 1'b0}) begin n_fail++; $display("FAIL lb_req: addr %h be %b we %b expected 00001000 1000 0", o_addr, o_be, o_we); end
        n_checks++; if (o_req_cycles !== 3 || o_stable !== 1'b1 || o_ready_wait !== 1'b0) begin n_fail++; $display("FAIL lb_hold: req_cycles %0d stable %b ready %b expected 3 1 0", o_req_cycles, o_stable, o_ready_wait); end
        n_checks++; if ({o_wb_valid, o_wb_data, o_wb_rd, o_wb_rd_wr} !== {1'b1, 32'hFFFF_FF80, 5'd7, 1'b1}) begin n_fail++; $display("FAIL lb_wb: valid %b data %h rd %0d rd_wr %b expected 1 ffffff80 7 1", o_wb_valid, o_wb_data, o_wb_rd, o_wb_rd_wr); end
        n_checks++; if ({o_req_after, o_ready_after, o_wb_valid2} !== 3'b010) begin n_fail++; $display("FAIL lb_after: req %b ready %b wb_valid_next %b expected 0 1 0", o_req_after, o_ready_after, o_wb_valid2); end
        mem_txn(mk(OP_LOAD, 3'b100, 5'd7), 32'h1003, 32'h0, 32'h80FF_0000, 1, 0);
        n_checks++; if ({o_wb_valid, o_wb_data} !== {1'b1, 32'h0000_0080}) begin n_fail++; $display("FAIL lbu_wb: valid %b data %h expected 1 00000080", o_wb_valid, o_wb_data); end
        mem_txn(mk(OP_LOAD, 3'b001, 5'd2), 32'h1002, 32'h0, 32'h80FF_0000, 1, 0);
        n_checks++; if ({o_be, o_wb_data} !== {4'b1100, 32'hFFFF_80FF}) begin n_fail++; $display("FAIL lh_wb: be %b data %h expected 1100 ffff80ff", o_be, o_wb_data); end
        mem_txn(mk(OP_LOAD, 3'b101, 5'd2), 32'h1002, 32'h0, 32'h80FF_0000, 1, 0);
        n_checks++; if (o_wb_data !== 32'h0000_80FF) begin n_fail++; $display("FAIL lhu_wb: got %h expected 000080ff", o_wb_data); end
    endtask

    task automatic test_store;
        mem_txn(mk(OP_STORE, 3'b001, 5'd3), 32'h2002, 32'hDEAD_BEEF, 32'h0, 2, 0);
        n_checks++; if ({o_we, o_be, o_addr, o_wdata} !== {1'b1, 4'b1100, 32'h2000, 32'hBEEF_BEEF}) begin n_fail++; $display("FAIL sh_req: we %b be %b addr %h wdata %h expected 1 1100 00002000 beefbeef", o_we, o_be, o_addr, o_wdata); end
        n_checks++; if ({o_wb_valid, o_wb_rd_wr} !== 2'b10) begin n_fail++; $display("FAIL sh_wb: valid %b rd_wr %b expected 1 0", o_wb_valid, o_wb_rd_wr); end
        mem_txn(mk(OP_STORE, 3'b000, 5'd3), 32'h2001, 32'h0000_00AB, 32'h0, 1, 0);
        n_checks++; if ({o_be, o_wdata} !== {4'b0010, 32'hABAB_ABAB}) begin n_fail++; $display("FAIL sb_req: be %b wdata %h expected 0010 abababab", o_be, o_wdata); end
        mem_txn(mk(OP_STORE, 3'b111, 5'd3), 32'h2004, 32'h1357_9BDF, 32'h0, 1, 0);
        n_checks++; if ({o_be, o_wdata} !== {4'b1111, 32'h1357_9BDF}) begin n_fail++; $display("FAIL sw_undef_f3: be %b wdata %h expected 1111 13579bdf", o_be, o_wdata); end
    endtask

    task automatic test_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
        ex_valid = 1'b1; ex_instr = mk(OP_LOAD, 3'b010, 5'd9); ex_result = 32'h3001; ex_rd_wr = 1'b1;
        step;
        ex_valid = 1'b0;
        n_checks++; if ({mem_req, wb_valid, wb_misalign, wb_rd_wr, ex_ready} !== 5'b01101) begin n_fail++; $display("FAIL lw_trap: req %b valid %b mis %b rd_wr %b ready %b expected 0 1 1 0 1", mem_req, wb_valid, wb_misalign, wb_rd_wr, ex_ready); end
        n_checks++; if (wb_data !== 32'h3001) begin n_fail++; $display("FAIL lw_trap_data: got %h expected 00003001", wb_data); end
        step;
`else
        mem_txn(mk(OP_LOAD, 3'b010, 5'd9), 32'h3001, 32'h0, 32'h1122_3344, 1, 0);
        n_checks++; if ({o_addr, o_be} !== {32'h3000, 4'b1111}) begin n_fail++; $display("FAIL lw_align: addr %h be %b expected 00003000 1111", o_addr, o_be); end
        n_checks++; if ({o_wb_valid, o_wb_data, wb_misalign} !== {1'b1, 32'h1122_3344, 1'b0}) begin n_fail++; $display("FAIL lw_align_wb: valid %b data %h mis %b expected 1 11223344 0", o_wb_valid, o_wb_data, wb_misalign); end
`endif
    endtask

    task automatic test_flush;
        mem_txn(mk(OP_LOAD, 3'b010, 5'd4), 32'h4000, 32'h0, 32'hCAFE_F00D, 2, 1);
        n_checks++; if ({o_req_cycles == 2, o_wb_valid, o_req_after, o_ready_after} !== 4'b1001) begin n_fail++; $display("FAIL flush_wait: req_cycles %0d wb_valid %b req %b ready %b expected 2 0 0 1", o_req_cycles, o_wb_valid, o_req_after, o_ready_after); end
        ex_valid = 1'b1; flush = 1'b1; ex_instr = mk(OP_LOAD, 3'b010, 5'd4); ex_result = 32'h4000;
        step;
        n_checks++; if ({mem_req, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_idle: req %b valid %b expected 0 0", mem_req, wb_valid); end
        flush = 1'b0; ex_instr = mk(OP_ALU, 3'b000, 5'd10); ex_result = 32'h55;
        step;
        flush = 1'b1; ex_result = 32'h66;
        n_checks++; if ({wb_valid, wb_data} !== {1'b1, 32'h55}) begin n_fail++; $display("FAIL flush_pending: valid %b data %h expected 1 00000055", wb_valid, wb_data); end
        step;
        ex_valid = 1'b0; flush = 1'b0;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pending_next: got %b expected 0", wb_valid); end
    endtask

    task automatic test_reset_mid;
        ex_valid = 1'b1; ex_instr = mk(OP_LOAD, 3'b010, 5'd11); ex_result = 32'h5000;
        step;
        ex_valid = 1'b0;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req: got %b expected 1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({mem_req, ex_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_async: req %b ready %b expected 0 1", mem_req, ex_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step;
        mem_ack = 1'b0;
        n_checks++; if ({mem_req, wb_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_late_ack: req %b valid %b expected 0 0", mem_req, wb_valid); end
        ex_valid = 1'b1; ex_instr = mk(OP_ALU, 3'b000, 5'd6); ex_result = 32'h77; ex_rd_wr = 1'b1;
        step;
        ex_valid = 1'b0;
        n_checks++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h77, 5'd6}) begin n_fail++; $display("FAIL rst_then_add: valid %b data %h rd %0d expected 1 00000077 6", wb_valid, wb_data, wb_rd); end
        step;
    endtask

    initial begin
        test_reset;
        test_passthrough;
        test_back_to_back;
        test_load;
        test_store;
        test_misalign;
        test_flush;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
